// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: steps one vector ALU instruction through the VRF/ALU
// datapath in LANE_W-bit beats. It issues register-file reads, ALU strobes and
// byte-masked writebacks, then pulses done when the last beat is written.
// Optional feature macro: VSEQ_VSTART_EN (honor issue_vstart, drive vstart_clr).
module vector_alu_sequencer #(
    parameter int VLEN    = 256,
    parameter int LANE_W  = 64,
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [5:0]                        issue_op,
    input  logic [4:0]                        issue_vd,
    input  logic [4:0]                        issue_vs1,
    input  logic [4:0]                        issue_vs2,
    input  logic [1:0]                        issue_sew,
    input  logic [XLEN-1:0]                   issue_vl,
    input  logic [XLEN-1:0]                   issue_vstart,
    input  logic                              hold,
    output logic                              rf_rd_en,
    output logic [4:0]                        rf_rd_addr_a,
    output logic [4:0]                        rf_rd_addr_b,
    output logic [$clog2(VLEN/LANE_W)-1:0]    rf_rd_beat,
    output logic                              alu_valid,
    output logic [5:0]                        alu_op,
    output logic [1:0]                        alu_sew,
    output logic                              wb_en,
    output logic [4:0]                        wb_addr,
    output logic [$clog2(VLEN/LANE_W)-1:0]    wb_beat,
    output logic [LANE_W/8-1:0]               wb_byte_en,
    output logic                              done,
    output logic                              vstart_clr
);

    localparam int LB    = LANE_W / 8;
    localparam int NBEAT = VLEN / LANE_W;
    localparam int BW    = $clog2(NBEAT);
    localparam int VB    = VLEN / 8;
    localparam int WW    = $clog2(VB) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic          valid;
        logic [4:0]    vd;
        logic [BW-1:0] beat;
        logic [LB-1:0] mask;
    } beat_t;

    state_t        state, state_next;
    logic          accept;
    logic          pipe_busy;
    beat_t         pipe [ALU_LAT+1];
    beat_t         rd_beat;

    logic [5:0]    op_q;
    logic [1:0]    sew_q;
    logic [4:0]    vd_q, vs1_q, vs2_q;
    logic [WW-1:0] win_lo_q, win_hi_q;
    logic [BW-1:0] beat_q, last_q;

    logic [XLEN-1:0] vlmax, vl_clamp, vstart_eff;
    logic            empty_instr;
    logic [WW-1:0]   win_lo_n, win_hi_n;
    logic [BW-1:0]   first_n, last_n;
    logic [LB-1:0]   rd_mask;
    logic [WW:0]     byte_idx;

`ifndef VSEQ_VSTART_EN
    logic unused_vstart;
    assign unused_vstart = ^issue_vstart;
`endif

    // Decode the issued instruction into a clamped byte window and beat range
    always_comb begin
        vlmax = XLEN'(VB) >> issue_sew;
        vl_clamp = (issue_vl > vlmax) ? vlmax : issue_vl;
`ifdef VSEQ_VSTART_EN
        vstart_eff = issue_vstart;
`else
        vstart_eff = '0;
`endif
        empty_instr = (vl_clamp == '0) || (vstart_eff >= vl_clamp);
        win_lo_n = WW'(vstart_eff << issue_sew);
        win_hi_n = WW'(vl_clamp << issue_sew);
        first_n = BW'(win_lo_n / WW'(LB));
        last_n = BW'((win_hi_n - WW'(1)) / WW'(LB));
    end

    // Byte mask of the beat being read: bytes inside [win_lo, win_hi)
    always_comb begin
        rd_mask = '0;
        byte_idx = '0;
        for (int k = 0; k < LB; k++) begin
            byte_idx = (WW+1)'(beat_q) * (WW+1)'(LB) + (WW+1)'(k);
            rd_mask[k] = (byte_idx >= {1'b0, win_lo_q}) && (byte_idx < {1'b0, win_hi_q});
        end
        rd_beat = {1'b1, vd_q, beat_q, rd_mask};
    end

    // A beat is still in flight if it sits in any stage before writeback
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < ALU_LAT; i++) begin
            pipe_busy = pipe_busy | pipe[i].valid;
        end
    end

    // Next-state and handshake/strobe decode
    always_comb begin
        state_next = state;
        issue_ready = 1'b0;
        rf_rd_en = 1'b0;
        done = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    accept = 1'b1;
                    state_next = empty_instr ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    rf_rd_en = 1'b1;
                    if (beat_q == last_q) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch instruction fields on accept and walk the beat index while reading
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            sew_q <= '0;
            vd_q <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            win_lo_q <= '0;
            win_hi_q <= '0;
            beat_q <= '0;
            last_q <= '0;
        end else if (accept) begin
            op_q <= issue_op;
            sew_q <= issue_sew;
            vd_q <= issue_vd;
            vs1_q <= issue_vs1;
            vs2_q <= issue_vs2;
            win_lo_q <= empty_instr ? '0 : win_lo_n;
            win_hi_q <= empty_instr ? '0 : win_hi_n;
            beat_q <= empty_instr ? '0 : first_n;
            last_q <= empty_instr ? '0 : last_n;
        end else if (rf_rd_en) begin
            beat_q <= beat_q + BW'(1);
        end
    end

    // Beat pipeline: stage 0 is the ALU stage, stage ALU_LAT is writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ALU_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= rf_rd_en ? rd_beat : '0;
            for (int i = 1; i <= ALU_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rf_rd_addr_a = vs1_q;
    assign rf_rd_addr_b = vs2_q;
    assign rf_rd_beat   = beat_q;
    assign alu_valid    = pipe[0].valid;
    assign alu_op       = op_q;
    assign alu_sew      = sew_q;
    assign wb_en        = pipe[ALU_LAT].valid;
    assign wb_addr      = pipe[ALU_LAT].vd;
    assign wb_beat      = pipe[ALU_LAT].beat;
    assign wb_byte_en   = pipe[ALU_LAT].mask;
`ifdef VSEQ_VSTART_EN
    assign vstart_clr   = done;
`else
    assign vstart_clr   = 1'b0;
`endif

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb_vector_alu_sequencer: directed and randomized instructions compared per
// cycle against an element-level reference model of the sequencer.
module tb_vector_alu_sequencer;

    localparam int VLEN    = 256;
    localparam int LANE_W  = 64;
    localparam int XLEN    = 32;
    localparam int ALU_LAT = 1;
    localparam int LB      = LANE_W / 8;
    localparam int NBEAT   = VLEN / LANE_W;
    localparam int MAXC    = 64;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_op;
    logic [4:0]  issue_vd, issue_vs1, issue_vs2;
    logic [1:0]  issue_sew;
    logic [31:0] issue_vl, issue_vstart;
    logic        hold;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [1:0]  rf_rd_beat;
    logic        alu_valid;
    logic [5:0]  alu_op;
    logic [1:0]  alu_sew;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [1:0]  wb_beat;
    logic [7:0]  wb_byte_en;
    logic        done;
    logic        vstart_clr;

    int checks = 0;
    int failures = 0;

    bit       exp_rd [MAXC];
    int       exp_rd_beat [MAXC];
    bit       exp_alu [MAXC];
    bit       exp_wb [MAXC];
    int       exp_wb_beat [MAXC];
    logic [7:0] exp_wb_mask [MAXC];
    bit       hold_pat [MAXC];
    int       exp_done;

    vector_alu_sequencer #(
        .VLEN(VLEN), .LANE_W(LANE_W), .XLEN(XLEN), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2),
        .issue_sew(issue_sew), .issue_vl(issue_vl), .issue_vstart(issue_vstart),
        .hold(hold),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_beat(rf_rd_beat),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_sew(alu_sew),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_beat(wb_beat), .wb_byte_en(wb_byte_en),
        .done(done), .vstart_clr(vstart_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference: mark every byte of every active element, then issue every beat
    // that contains a marked byte, in ascending order, skipping held cycles.
    task automatic buildModel(input int sew, input longint vl, input longint vstart);
        int eb, vlmax, c, last_rc;
        longint vlc, vs;
        bit bytes [VLEN/8];
        logic [7:0] m;
        eb = 1 << sew;
        vlmax = (VLEN / 8) / eb;
        vlc = (vl > vlmax) ? vlmax : vl;
`ifdef VSEQ_VSTART_EN
        vs = vstart;
`else
        vs = 0;
`endif
        for (int i = 0; i < VLEN/8; i++) bytes[i] = 1'b0;
        for (longint e = vs; e < vlc; e++)
            for (int j = 0; j < eb; j++) bytes[int'(e) * eb + j] = 1'b1;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 0; exp_rd_beat[i] = 0; exp_alu[i] = 0;
            exp_wb[i] = 0; exp_wb_beat[i] = 0; exp_wb_mask[i] = 8'h00;
        end
        c = 1;
        last_rc = -1;
        for (int b = 0; b < NBEAT; b++) begin
            for (int k = 0; k < LB; k++) m[k] = bytes[b * LB + k];
            if (m != 8'h00) begin
                while (hold_pat[c]) c++;
                exp_rd[c] = 1;
                exp_rd_beat[c] = b;
                exp_alu[c + 1] = 1;
                exp_wb[c + 1 + ALU_LAT] = 1;
                exp_wb_beat[c + 1 + ALU_LAT] = b;
                exp_wb_mask[c + 1 + ALU_LAT] = m;
                last_rc = c;
                c++;
            end
        end
        exp_done = (last_rc < 0) ? 1 : last_rc + 1 + ALU_LAT;
    endtask

    task automatic clearHold();
        for (int i = 0; i < MAXC; i++) hold_pat[i] = 1'b0;
    endtask

    task automatic waitReady();
        int guard;
        guard = 0;
        #1;
        while (!issue_ready && guard < 40) begin
            @(negedge clk);
            issue_valid = 1'b0;
            #1;
            guard++;
        end
        checkOutput("ready_wait", issue_ready, 1);
    endtask

    // Issue one instruction at cycle 0 and check every output through done+1
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                                 input logic [4:0] vs2, input logic [1:0] sew,
                                 input logic [31:0] vl, input logic [31:0] vstart);
        bit vclr;
        buildModel(int'(sew), longint'(vl), longint'(vstart));
        waitReady();
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = op; issue_vd = vd; issue_vs1 = vs1; issue_vs2 = vs2;
        issue_sew = sew; issue_vl = vl; issue_vstart = vstart;
        hold = 1'($urandom_range(0, 1));
        #1;
        checkOutput("ready_c0", issue_ready, 1);
        checkOutput("rd_idle", rf_rd_en, 0);
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            if (c <= exp_done) begin
                issue_valid = 1'($urandom_range(0, 1));
                issue_op = 6'($urandom); issue_vd = 5'($urandom);
                issue_vs1 = 5'($urandom); issue_vs2 = 5'($urandom);
                issue_sew = 2'($urandom); issue_vl = $urandom_range(0, 40);
                issue_vstart = $urandom_range(0, 40);
            end else begin
                issue_valid = 1'b0;
            end
            hold = hold_pat[c];
            #1;
            checkOutput($sformatf("rd_en_c%0d", c), rf_rd_en, exp_rd[c]);
            if (exp_rd[c]) begin
                checkOutput($sformatf("rd_beat_c%0d", c), rf_rd_beat, exp_rd_beat[c]);
                checkOutput("rd_addr_a", rf_rd_addr_a, vs1);
                checkOutput("rd_addr_b", rf_rd_addr_b, vs2);
            end
            checkOutput($sformatf("alu_valid_c%0d", c), alu_valid, exp_alu[c]);
            checkOutput($sformatf("wb_en_c%0d", c), wb_en, exp_wb[c]);
            if (exp_wb[c]) begin
                checkOutput($sformatf("wb_beat_c%0d", c), wb_beat, exp_wb_beat[c]);
                checkOutput("wb_addr", wb_addr, vd);
                checkOutput($sformatf("wb_byte_en_c%0d", c), wb_byte_en, exp_wb_mask[c]);
            end
            checkOutput($sformatf("done_c%0d", c), done, (c == exp_done));
`ifdef VSEQ_VSTART_EN
            vclr = (c == exp_done);
`else
            vclr = 1'b0;
`endif
            checkOutput($sformatf("vstart_clr_c%0d", c), vstart_clr, vclr);
            checkOutput($sformatf("ready_c%0d", c), issue_ready, (c > exp_done));
            checkOutput("alu_op", alu_op, op);
            checkOutput("alu_sew", alu_sew, sew);
        end
    endtask

    // Abort a vl=8 instruction with reset during cycle 3
    task automatic resetMidRun();
        waitReady();
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op = 6'h05; issue_vd = 5'd3; issue_vs1 = 5'd4; issue_vs2 = 5'd5;
        issue_sew = 2'd2; issue_vl = 32'd8; issue_vstart = 32'd0;
        hold = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            issue_valid = 1'b0;
            #1;
            checkOutput("rst_run_rd_en", rf_rd_en, 1);
            checkOutput("rst_run_rd_beat", rf_rd_beat, c - 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_ready", issue_ready, 1);
        checkOutput("rst_mid_alu_valid", alu_valid, 0);
        for (int c = 4; c < 10; c++) begin
            checkOutput("rst_mid_wb_en", wb_en, 0);
            checkOutput("rst_mid_done", done, 0);
            checkOutput("rst_mid_rd_en", rf_rd_en, 0);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_op = '0; issue_vd = '0; issue_vs1 = '0; issue_vs2 = '0;
        issue_sew = '0; issue_vl = '0; issue_vstart = '0;
        hold = 1'b0;
        clearHold();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", issue_ready, 1);
        checkOutput("reset_rd_en", rf_rd_en, 0);
        checkOutput("reset_alu_valid", alu_valid, 0);
        checkOutput("reset_wb_en", wb_en, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_vstart_clr", vstart_clr, 0);
        checkOutput("reset_alu_op", alu_op, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed scenarios");
        applyStimulus(6'h00, 5'd1, 5'd2, 5'd3, 2'd2, 32'd8, 32'd0);
        applyStimulus(6'h01, 5'd4, 5'd5, 5'd6, 2'd2, 32'd5, 32'd0);
        applyStimulus(6'h02, 5'd7, 5'd8, 5'd9, 2'd0, 32'd20, 32'd10);
        applyStimulus(6'h03, 5'd10, 5'd11, 5'd12, 2'd2, 32'd20, 32'd0);
        applyStimulus(6'h04, 5'd13, 5'd14, 5'd15, 2'd2, 32'd0, 32'd0);
        applyStimulus(6'h05, 5'd16, 5'd17, 5'd18, 2'd1, 32'd4, 32'd6);
        applyStimulus(6'h06, 5'd19, 5'd20, 5'd21, 2'd3, 32'hFFFF_FFF0, 32'd1);
        hold_pat[2] = 1'b1;
        hold_pat[3] = 1'b1;
        applyStimulus(6'h07, 5'd22, 5'd23, 5'd24, 2'd2, 32'd8, 32'd0);
        clearHold();

        $display("[TB] reset during run");
        resetMidRun();
        applyStimulus(6'h08, 5'd25, 5'd26, 5'd27, 2'd2, 32'd8, 32'd0);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 60; n++) begin
            logic [31:0] rvl;
            for (int i = 0; i < MAXC; i++)
                hold_pat[i] = (i < 20) && ($urandom_range(0, 3) == 0);
            rvl = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 40);
            applyStimulus(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                          2'($urandom), rvl, $urandom_range(0, 40));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
